// File: rtl/rv_mem_bridge.sv
// Memory bridge between the multicycle core and a variable-latency memory.
// Turns the core's level-held read/write strobes into a registered req/ack
// handshake, stalls the core until completion, and keeps a sticky error code
// for timeouts, misaligned addresses and conflicting read+write strobes.

module rv_mem_bridge #(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_rd,
    input  logic          core_wr,
    input  logic [AW-1:0] core_addr,
    input  logic [31:0]   core_wdata,
    output logic [31:0]   core_rdata,
    output logic          core_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic [1:0]    err_code,
    input  logic          err_clr
);

    // A zero TIMEOUT disables the watchdog; keep a 1-bit timer so widths stay legal.
    localparam bit          TimeoutEn = (TIMEOUT != 0);
    localparam int unsigned TW        = TimeoutEn ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [TW-1:0] TimerLimit = TW'(TIMEOUT);
    localparam logic [TW-1:0] TimerLast  = TimeoutEn ? TW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] ErrNone     = 2'b00;
    localparam logic [1:0] ErrTimeout  = 2'b01;
    localparam logic [1:0] ErrMisalign = 2'b10;
    localparam logic [1:0] ErrConflict = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic            req_d;
    logic            we_d;
    logic [AW-1:0]   addr_d;
    logic [31:0]     wdata_d;
    logic [31:0]     rdata_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      err_d;
    logic            err_event;
    logic [1:0]      err_val;

    // The core is frozen while it asks for memory, except in the one DONE cycle.
    assign core_stall = (core_rd | core_wr) & (state_q != StDone);

    // Next-state and datapath-register decode; all values hold by default.
    always_comb begin
        state_d   = state_q;
        req_d     = mem_req;
        we_d      = mem_we;
        addr_d    = mem_addr;
        wdata_d   = mem_wdata;
        rdata_d   = core_rdata;
        timer_d   = timer_q;
        err_event = 1'b0;
        err_val   = ErrNone;

        unique case (state_q)
            StIdle: begin
                if (core_rd | core_wr) begin
                    addr_d  = core_addr;
                    wdata_d = core_wdata;
                    we_d    = core_wr;
                    if (core_addr[1:0] != 2'b00) begin
                        // Misaligned: never touch memory, just release the core.
                        state_d   = StDone;
                        err_event = 1'b1;
                        err_val   = ErrMisalign;
                    end else begin
                        req_d   = 1'b1;
                        timer_d = '0;
                        state_d = StBusy;
                        // Conflicting strobes proceed as a write (mem_we follows core_wr).
                        if (core_rd & core_wr) begin
                            err_event = 1'b1;
                            err_val   = ErrConflict;
                        end
                    end
                end
            end

            StBusy: begin
                if (mem_ack) begin
                    // Ack has priority over a simultaneous timeout.
                    req_d   = 1'b0;
                    state_d = StDone;
                    if (!mem_we) begin
                        rdata_d = mem_rdata;
                    end
                end else if (TimeoutEn && (timer_q == TimerLast)) begin
                    req_d     = 1'b0;
                    rdata_d   = '0;
                    state_d   = StDone;
                    err_event = 1'b1;
                    err_val   = ErrTimeout;
                end else if (timer_q != TimerLimit) begin
                    // Saturating: the timer never wraps.
                    timer_d = timer_q + TW'(1);
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    // Sticky error: first error wins, clear is overridden by a same-cycle event.
    always_comb begin
        err_d = err_code;
        if (err_event && ((err_code == ErrNone) || err_clr)) begin
            err_d = err_val;
        end else if (err_clr) begin
            err_d = ErrNone;
        end
    end

    // State and registered outputs; reset aborts any transaction immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rdata <= '0;
            timer_q    <= '0;
            err_code   <= ErrNone;
        end else begin
            state_q    <= state_d;
            mem_req    <= req_d;
            mem_we     <= we_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            core_rdata <= rdata_d;
            timer_q    <= timer_d;
            err_code   <= err_d;
        end
    end

endmodule

// File: tb/tb_rv_mem_bridge.sv
// Self-checking bench for rv_mem_bridge: directed scenarios followed by random
// transactions, all checked against a transaction-level model of the bridge.

module tb_rv_mem_bridge;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst;
    logic        core_rd;
    logic        core_wr;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [1:0]  err_code;
    logic        err_clr;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: what the core should see as read data and sticky error.
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;

    rv_mem_bridge #(
        .AW     (32),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .core_rd   (core_rd),
        .core_wr   (core_wr),
        .core_addr (core_addr),
        .core_wdata(core_wdata),
        .core_rdata(core_rdata),
        .core_stall(core_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .err_code  (err_code),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One core access. delay = BUSY cycle index at which memory acks; >= TO means never.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int delay,
                          input logic [31:0] rd_val, input bit clr);
        bit         mis;
        bit         tmo;
        int         nb;
        logic [1:0] req_ev;
        mis = (addr[1:0] != 2'b00);
        tmo = !mis && (delay >= int'(TO));
        nb  = mis ? 0 : (tmo ? int'(TO) : delay + 1);

        @(negedge clk);
        core_rd    = rd;
        core_wr    = wr;
        core_addr  = addr;
        core_wdata = wdata;
        err_clr    = clr;
        mem_ack    = 1'b0;
        #1;
        check("req_stall", core_stall, 1);
        check("req_memreq", mem_req, 0);

        // Errors raised in the request cycle, including the clear/event race.
        req_ev = mis ? 2'b10 : ((rd && wr) ? 2'b11 : 2'b00);
        if (clr) exp_err = req_ev;
        else if (exp_err == 2'b00) exp_err = req_ev;

        for (int j = 0; j < nb; j++) begin
            @(negedge clk);
            err_clr   = 1'b0;
            mem_ack   = (j == delay);
            mem_rdata = (j == delay) ? rd_val : $urandom;
            #1;
            check("busy_req", mem_req, 1);
            check("busy_stall", core_stall, 1);
            check("busy_we", mem_we, wr);
            check("busy_addr", mem_addr, addr);
            check("busy_wdata", mem_wdata, wdata);
        end

        @(negedge clk);
        err_clr   = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (!mis) begin
            if (tmo) begin
                exp_rdata = '0;
                if (exp_err == 2'b00) exp_err = 2'b01;
            end else if (!wr) begin
                exp_rdata = rd_val;
            end
        end
        #1;
        check("done_stall", core_stall, 0);
        check("done_req", mem_req, 0);
        check("done_rdata", core_rdata, exp_rdata);
        check("done_err", err_code, exp_err);
    endtask

    task automatic go_idle(input bit clr);
        @(negedge clk);
        core_rd = 1'b0;
        core_wr = 1'b0;
        mem_ack = 1'b0;
        err_clr = clr;
        #1;
        check("idle_stall", core_stall, 0);
        check("idle_req", mem_req, 0);
        check("idle_err", err_code, exp_err);
        check("idle_rdata", core_rdata, exp_rdata);
        if (clr) exp_err = 2'b00;
    endtask

    task automatic spurious_ack();
        @(negedge clk);
        core_rd   = 1'b0;
        core_wr   = 1'b0;
        err_clr   = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("spur_rdata", core_rdata, exp_rdata);
        check("spur_stall", core_stall, 0);
        check("spur_req", mem_req, 0);
    endtask

    task automatic reset_mid_busy();
        @(negedge clk);
        core_rd   = 1'b1;
        core_wr   = 1'b0;
        core_addr = 32'h300;
        err_clr   = 1'b0;
        mem_ack   = 1'b0;
        @(negedge clk);                // mem_req rises here
        #1 check("rst_pre_req", mem_req, 1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst     = 1'b0;
        core_rd = 1'b0;
        #1;
        exp_rdata = '0;
        exp_err   = 2'b00;
        check("rst_async_req", mem_req, 0);
        check("rst_async_rdata", core_rdata, 0);
        check("rst_async_addr", mem_addr, 0);
        check("rst_async_err", err_code, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("late_ack_rdata", core_rdata, 0);
        check("late_ack_req", mem_req, 0);
        check("late_ack_stall", core_stall, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        core_rd    = 1'b0;
        core_wr    = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        err_clr    = 1'b0;
        exp_rdata  = '0;
        exp_err    = 2'b00;

        repeat (2) @(negedge clk);
        #1;
        check("reset_req", mem_req, 0);
        check("reset_we", mem_we, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_wdata", mem_wdata, 0);
        check("reset_rdata", core_rdata, 0);
        check("reset_err", err_code, 0);
        check("reset_stall", core_stall, 0);
        @(negedge clk);
        rst = 1'b1;
        go_idle(1'b0);

        // Zero-wait read, then 3-wait write.
        access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h1234_5678, 1'b0);
        access(1'b0, 1'b1, 32'h204, 32'hCAFE_F00D, 3, 32'h5555_AAAA, 1'b0);
        go_idle(1'b0);

        // Timeout, then clear.
        access(1'b1, 1'b0, 32'h108, 32'h0, 99, 32'h0BAD_0BAD, 1'b0);
        go_idle(1'b1);
        go_idle(1'b0);

        // Misaligned, then aligned read keeps the sticky error.
        access(1'b1, 1'b0, 32'h104, 32'h0, 0, 32'hA5A5_0001, 1'b0);
        access(1'b1, 1'b0, 32'h102, 32'h0, 0, 32'h0, 1'b0);
        access(1'b1, 1'b0, 32'h10C, 32'h0, 1, 32'h7777_1111, 1'b0);
        go_idle(1'b1);
        go_idle(1'b0);

        // Ack exactly on the timeout-limit cycle.
        access(1'b1, 1'b0, 32'h110, 32'h0, int'(TO) - 1, 32'h0F0F_1234, 1'b0);
        spurious_ack();

        // rd+wr together, then clear racing a misaligned event.
        access(1'b1, 1'b1, 32'h120, 32'hFEED_0001, 1, 32'h9999_9999, 1'b0);
        access(1'b1, 1'b0, 32'h125, 32'h0, 0, 32'h0, 1'b1);
        go_idle(1'b1);

        reset_mid_busy();
        access(1'b1, 1'b0, 32'h400, 32'h0, 2, 32'h4242_4242, 1'b0);

        for (int i = 0; i < 250; i++) begin
            int unsigned op;
            int unsigned kind;
            logic [31:0] a;
            op = $urandom_range(0, 7);
            if (op == 0) begin
                go_idle($urandom_range(0, 3) == 0);
            end else if (op == 1) begin
                spurious_ack();
            end else begin
                kind = $urandom_range(0, 9);
                a    = $urandom & 32'hFFFF_FFFC;
                if (kind <= 4) begin
                    access(1'b1, 1'b0, a, $urandom, $urandom_range(0, TO + 1), $urandom,
                           $urandom_range(0, 7) == 0);
                end else if (kind <= 7) begin
                    access(1'b0, 1'b1, a, $urandom, $urandom_range(0, TO - 1), $urandom,
                           $urandom_range(0, 7) == 0);
                end else if (kind == 8) begin
                    access(1'b1, 1'b1, a, $urandom, $urandom_range(0, TO - 1), $urandom,
                           $urandom_range(0, 7) == 0);
                end else begin
                    a = a | 32'($urandom_range(1, 3));
                    access(1'b1, 1'b0, a, $urandom, 0, $urandom,
                           $urandom_range(0, 7) == 0);
                end
            end
        end
        go_idle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
